// File: rtl/vend_pkg.sv
// Shared coin definitions for the coin front end and the vending FSM.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_NICKEL,
        COIN_DIME
    } coin_t;

    localparam int unsigned NICKEL_CENTS = 5;
    localparam int unsigned DIME_CENTS   = 10;

    function automatic int unsigned coin_cents(input coin_t coin);
        case (coin)
            COIN_NICKEL: coin_cents = NICKEL_CENTS;
            COIN_DIME:   coin_cents = DIME_CENTS;
            default:     coin_cents = 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_sense_channel.sv
// One coin-slot sensor: synchroniser, debouncer, post-reset arming, jam counter.
module coin_sense_channel #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic req,
    output logic jam_hit
);

    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned JW  = $clog2(JAM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   synced;
    logic                   stable;
    logic                   stable_q;
    logic                   armed;
    logic [DBW-1:0]         db_cnt;
    logic [JW-1:0]          jam_cnt;
    logic [JW-1:0]          jam_cnt_next_c;

    assign synced = sync_q[SYNC_STAGES-1];

    // Jam counter: counts debounced-high cycles, saturating at the jam threshold.
    always_comb begin
        jam_cnt_next_c = jam_cnt;
        if (!stable) begin
            jam_cnt_next_c = '0;
        end else if (jam_cnt != JW'(JAM_CYCLES)) begin
            jam_cnt_next_c = jam_cnt + JW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            valid_q  <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            armed    <= 1'b0;
            db_cnt   <= '0;
            jam_cnt  <= '0;
            req      <= 1'b0;
            jam_hit  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};

            if (synced == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= synced;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end

            // Arm only once the sync chain holds post-reset samples that read low,
            // so a coin already in the slot at reset release is never counted.
            if (valid_q[SYNC_STAGES-1] && !synced && !stable) begin
                armed <= 1'b1;
            end

            stable_q <= stable;
            req      <= stable & ~stable_q & armed;
            jam_cnt  <= jam_cnt_next_c;
            jam_hit  <= (jam_cnt_next_c == JW'(JAM_CYCLES));
        end
    end

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin front end: two sensor channels, dime-first arbitration with one-deep pending, sticky jam.
module coin_pulse_conditioner
    import vend_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic nickel_raw,
    input  logic dime_raw,
    output logic N,
    output logic D,
    output logic jam
);

    logic  nickel_req;
    logic  dime_req;
    logic  nickel_hit;
    logic  dime_hit;
    logic  nickel_pending;
    logic  dime_pending;
    logic  nickel_want_c;
    logic  dime_want_c;
    logic  jam_next_c;
    coin_t grant_c;

    coin_sense_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .JAM_CYCLES     (JAM_CYCLES)
    ) u_nickel (
        .clk    (clk),
        .rst    (rst),
        .raw    (nickel_raw),
        .req    (nickel_req),
        .jam_hit(nickel_hit)
    );

    coin_sense_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .JAM_CYCLES     (JAM_CYCLES)
    ) u_dime (
        .clk    (clk),
        .rst    (rst),
        .raw    (dime_raw),
        .req    (dime_req),
        .jam_hit(dime_hit)
    );

    // Dime wins a collision; the losing nickel waits one cycle in its pending slot.
    always_comb begin
        nickel_want_c = nickel_pending | nickel_req;
        dime_want_c   = dime_pending | dime_req;
        jam_next_c    = jam | nickel_hit | dime_hit;
        grant_c       = COIN_NONE;
        if (!jam_next_c) begin
            if (dime_want_c) begin
                grant_c = COIN_DIME;
            end else if (nickel_want_c) begin
                grant_c = COIN_NICKEL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            N              <= 1'b0;
            D              <= 1'b0;
            jam            <= 1'b0;
            nickel_pending <= 1'b0;
            dime_pending   <= 1'b0;
        end else begin
            jam <= jam_next_c;
            N   <= (grant_c == COIN_NICKEL);
            D   <= (grant_c == COIN_DIME);
            if (jam_next_c) begin
                nickel_pending <= 1'b0;
                dime_pending   <= 1'b0;
            end else begin
                nickel_pending <= (grant_c == COIN_NICKEL) ? (nickel_pending & nickel_req)
                                                           : nickel_want_c;
                dime_pending   <= (grant_c == COIN_DIME) ? (dime_pending & dime_req)
                                                         : dime_want_c;
            end
        end
    end

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Self-checking bench for coin_pulse_conditioner: directed scenarios plus randomized waveforms.
module tb_coin_pulse_conditioner;
    import vend_pkg::*;

    localparam int DB      = 4;
    localparam int LATENCY = 7;
    localparam int LEN     = 1200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nickel_raw = 1'b0;
    logic dime_raw = 1'b0;
    logic N;
    logic D;
    logic jam;

    int checks = 0;
    int errors = 0;

    bit nw[LEN];
    bit dw[LEN];
    bit nreq[LEN + 16];
    bit dreq[LEN + 16];
    bit en[LEN + 16];
    bit ed[LEN + 16];

    coin_pulse_conditioner dut (
        .clk       (clk),
        .rst       (rst),
        .nickel_raw(nickel_raw),
        .dime_raw  (dime_raw),
        .N         (N),
        .D         (D),
        .jam       (jam)
    );

    always #5 clk = ~clk;

    // Drive sensors before an edge, then sample just after it.
    task automatic step(input logic n, input logic d);
        @(negedge clk);
        nickel_raw = n;
        dime_raw   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int idle);
        @(negedge clk);
        rst        = 1'b1;
        nickel_raw = 1'b0;
        dime_raw   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < idle; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset(0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({N, D, jam} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got N/D/jam=%b expected 000", {N, D, jam});
        end
        do_reset(12);
        checks++;
        if ({N, D, jam} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got N/D/jam=%b expected 000", {N, D, jam});
        end
    endtask

    task automatic test_clean_nickel();
        int n_cnt = 0;
        int n_at  = -1;
        int d_cnt = 0;
        do_reset(6);
        for (int t = 0; t < 30; t++) begin
            step(t < 10, 1'b0);
            if (N) begin
                n_cnt++;
                if (n_at < 0) n_at = t;
            end
            if (D) d_cnt++;
        end
        checks++;
        if (n_cnt !== 1) begin
            errors++;
            $display("FAIL clean_nickel_count: got %0d N pulses expected 1", n_cnt);
        end
        checks++;
        if (n_at !== LATENCY) begin
            errors++;
            $display("FAIL clean_nickel_latency: got %0d cycles expected %0d", n_at, LATENCY);
        end
        checks++;
        if (d_cnt !== 0) begin
            errors++;
            $display("FAIL clean_nickel_no_dime: got %0d D pulses expected 0", d_cnt);
        end
    endtask

    task automatic test_glitch();
        int d_cnt;
        do_reset(6);
        for (int w = DB - 1; w <= DB; w++) begin
            d_cnt = 0;
            for (int t = 0; t < 25; t++) begin
                step(1'b0, t < w);
                if (D) d_cnt++;
            end
            checks++;
            if (d_cnt !== ((w >= DB) ? 1 : 0)) begin
                errors++;
                $display("FAIL glitch_width_%0d: got %0d D pulses expected %0d", w, d_cnt,
                         (w >= DB) ? 1 : 0);
            end
        end
    endtask

    task automatic test_simultaneous();
        int d_at = -1;
        int n_at = -1;
        int both = 0;
        do_reset(6);
        for (int t = 0; t < 30; t++) begin
            step(t < 10, t < 10);
            if (N && D) both++;
            if (D && d_at < 0) d_at = t;
            if (N && n_at < 0) n_at = t;
        end
        checks++;
        if (d_at !== LATENCY) begin
            errors++;
            $display("FAIL simul_dime_time: got %0d expected %0d", d_at, LATENCY);
        end
        checks++;
        if (n_at !== LATENCY + 1) begin
            errors++;
            $display("FAIL simul_nickel_time: got %0d expected %0d", n_at, LATENCY + 1);
        end
        checks++;
        if (both !== 0) begin
            errors++;
            $display("FAIL simul_overlap: got %0d overlapping cycles expected 0", both);
        end
    endtask

    task automatic test_jam();
        int d_cnt = 0;
        int n_cnt = 0;
        do_reset(6);
        for (int t = 0; t < 80; t++) begin
            step(1'b0, 1'b1);
            if (D) d_cnt++;
            if (t == 50) begin
                checks++;
                if (jam !== 1'b0) begin
                    errors++;
                    $display("FAIL jam_early: got jam=%b expected 0", jam);
                end
            end
        end
        checks++;
        if (jam !== 1'b1) begin
            errors++;
            $display("FAIL jam_set: got jam=%b expected 1", jam);
        end
        checks++;
        if (d_cnt !== 1) begin
            errors++;
            $display("FAIL jam_dime_count: got %0d D pulses expected 1", d_cnt);
        end
        for (int t = 0; t < 40; t++) begin
            step((t >= 10) && (t < 20), 1'b0);
            if (N) n_cnt++;
        end
        checks++;
        if (n_cnt !== 0 || jam !== 1'b1) begin
            errors++;
            $display("FAIL jam_blocks_nickel: got %0d N pulses jam=%b expected 0 pulses jam=1",
                     n_cnt, jam);
        end
        do_reset(2);
        checks++;
        if (jam !== 1'b0) begin
            errors++;
            $display("FAIL jam_cleared: got jam=%b expected 0", jam);
        end
    endtask

    task automatic test_reset_midflight();
        int n_cnt = 0;
        do_reset(6);
        for (int t = 0; t < 4; t++) step(1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst = 1'b0;
        for (int t = 0; t < 40; t++) begin
            step(1'b1, 1'b0);
            if (N) n_cnt++;
        end
        checks++;
        if (n_cnt !== 0) begin
            errors++;
            $display("FAIL midflight_no_pulse: got %0d N pulses expected 0", n_cnt);
        end
        n_cnt = 0;
        for (int t = 0; t < 40; t++) begin
            step((t >= 10) && (t < 20), 1'b0);
            if (N) n_cnt++;
        end
        checks++;
        if (n_cnt !== 1) begin
            errors++;
            $display("FAIL midflight_rearm: got %0d N pulses expected 1", n_cnt);
        end
    endtask

    // N, N, D coin sequence as the vending FSM would see it: order and total value.
    task automatic test_back_to_back();
        coin_t seen[$];
        int unsigned cents = 0;
        do_reset(6);
        for (int t = 0; t < 60; t++) begin
            step((t < 6) || (t >= 16 && t < 22), (t >= 32 && t < 38));
            if (N) seen.push_back(COIN_NICKEL);
            if (D) seen.push_back(COIN_DIME);
        end
        foreach (seen[i]) cents += coin_cents(seen[i]);
        checks++;
        if (seen.size() !== 3) begin
            errors++;
            $display("FAIL seq_count: got %0d pulses expected 3", seen.size());
        end else begin
            checks++;
            if (seen[0] !== COIN_NICKEL || seen[1] !== COIN_NICKEL || seen[2] !== COIN_DIME) begin
                errors++;
                $display("FAIL seq_order: got %s,%s,%s expected N,N,D",
                         seen[0].name(), seen[1].name(), seen[2].name());
            end
        end
        checks++;
        if (cents !== 20) begin
            errors++;
            $display("FAIL seq_cents: got %0d expected 20", cents);
        end
    endtask

    // Random coins and sub-threshold glitches; quiet gaps keep each event independent.
    task automatic gen_wave(output bit w[LEN]);
        int i;
        int width;
        foreach (w[k]) w[k] = 1'b0;
        i = $urandom_range(20, 6);
        while (i < LEN - 60) begin
            if ($urandom_range(3, 0) == 0) width = $urandom_range(DB - 1, 1);
            else width = $urandom_range(30, DB);
            for (int j = 0; j < width; j++) w[i + j] = 1'b1;
            i += width + $urandom_range(25, DB + 2);
        end
    endtask

    task automatic test_random();
        int run;
        int pn = 0;
        int pd = 0;
        gen_wave(nw);
        gen_wave(dw);
        foreach (nreq[k]) begin
            nreq[k] = 1'b0;
            dreq[k] = 1'b0;
            en[k]   = 1'b0;
            ed[k]   = 1'b0;
        end
        // A high run at least DB samples long is one coin, requested LATENCY-1 edges later.
        for (int e = 1; e < LEN; e++) begin
            if (nw[e] && !nw[e - 1]) begin
                run = 0;
                while (e + run < LEN && nw[e + run]) run++;
                if (run >= DB) nreq[e + LATENCY - 1] = 1'b1;
            end
            if (dw[e] && !dw[e - 1]) begin
                run = 0;
                while (e + run < LEN && dw[e + run]) run++;
                if (run >= DB) dreq[e + LATENCY - 1] = 1'b1;
            end
        end
        for (int c = 0; c < LEN + 15; c++) begin
            pn += int'(nreq[c]);
            pd += int'(dreq[c]);
            if (pd > 0) begin
                ed[c + 1] = 1'b1;
                pd--;
            end else if (pn > 0) begin
                en[c + 1] = 1'b1;
                pn--;
            end
        end
        do_reset(0);
        for (int e = 0; e < LEN; e++) begin
            step(nw[e], dw[e]);
            checks++;
            if (N !== en[e] || D !== ed[e]) begin
                errors++;
                $display("FAIL random_cycle_%0d: got N=%b D=%b expected N=%b D=%b",
                         e, N, D, en[e], ed[e]);
            end
        end
        checks++;
        if (jam !== 1'b0) begin
            errors++;
            $display("FAIL random_no_jam: got jam=%b expected 0", jam);
        end
    endtask

    initial begin
        test_reset();
        test_clean_nickel();
        test_glitch();
        test_simultaneous();
        test_jam();
        test_reset_midflight();
        test_back_to_back();
        for (int r = 0; r < 3; r++) test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
